// File: rtl/ipg_tx.sv
// ipg_tx: embeds pending request/response messages into idle control blocks of the 64b/66b TX stream.
module ipg_tx #(
    parameter int DATA_WIDTH = 64,
    parameter int HDR_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] encoded_tx_data_in,
    input  logic [HDR_WIDTH-1:0]  encoded_tx_hdr_in,
    output logic [DATA_WIDTH-1:0] encoded_tx_data,
    output logic [HDR_WIDTH-1:0]  encoded_tx_hdr,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_type,
    input  logic [5:0]            req_len,
    input  logic [DATA_WIDTH-1:0] req_data,
    input  logic                  resp_valid,
    output logic                  resp_ready,
    input  logic [5:0]            resp_len,
    input  logic [DATA_WIDTH-1:0] resp_data,
    input  logic                  tx_ipg_enable,
    output logic                  tx_ipg_busy,
    output logic                  tx_ipg_len_error,
    output logic [15:0]           tx_ipg_count
);
    localparam logic [1:0] IDLE = 2'd0, HOLD = 2'd1, CONT = 2'd2;
    localparam logic [63:0] IDLE_BLK = 64'h0000_0000_0000_001E;

    logic [1:0]  state;
    logic [7:0]  h_type, a_type;
    logic [5:0]  h_len, a_len;
    logic [63:0] h_data, a_data, a_mask;
    logic        eligible, acc_resp, acc_req, accept;

    assign resp_ready  = state == IDLE && tx_ipg_enable && !rst;
    assign req_ready   = resp_ready && !resp_valid;
    assign acc_resp    = resp_valid && resp_ready;
    assign acc_req     = req_valid && req_ready;
    assign accept      = acc_resp || acc_req;
    assign a_len       = acc_resp ? resp_len : req_len;
    assign a_data      = acc_resp ? resp_data : req_data;
    assign a_type      = acc_resp ? 8'hA3 : (req_type ? 8'hA2 : 8'hA1);
    assign eligible    = encoded_tx_hdr_in == 2'b10 && encoded_tx_data_in == IDLE_BLK;
    assign tx_ipg_busy = state != IDLE;

    // Bytes at or beyond len are zeroed so stale payload never reaches the line
    always_comb begin
        a_mask = '0;
        for (int i = 0; i < 8; i++)
            a_mask[i*8 +: 8] = a_len > 6'(i) ? 8'hFF : 8'h00;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            encoded_tx_data  <= IDLE_BLK;
            encoded_tx_hdr   <= 2'b10;
            tx_ipg_len_error <= 1'b0;
            tx_ipg_count     <= '0;
        end else begin
            tx_ipg_len_error <= accept && a_len > 6'd8;
            encoded_tx_hdr   <= encoded_tx_hdr_in;
            encoded_tx_data  <= (state == HOLD && eligible) ? {h_data[47:0], 2'b00, h_len, h_type} :
                                (state == CONT && eligible) ? {40'd0, h_data[63:48], 8'hA4} :
                                encoded_tx_data_in;
            case (state)
                IDLE: if (accept && a_len <= 6'd8) begin
                    state  <= HOLD;
                    h_type <= a_type;
                    h_len  <= a_len;
                    h_data <= a_data & a_mask;
                end
                HOLD: if (eligible) begin
                    state <= h_len <= 6'd6 ? IDLE : CONT;
                    if (h_len <= 6'd6)
                        tx_ipg_count <= tx_ipg_count + {15'd0, tx_ipg_count != 16'hFFFF};
                end
                CONT: if (eligible) begin
                    state        <= IDLE;
                    tx_ipg_count <= tx_ipg_count + {15'd0, tx_ipg_count != 16'hFFFF};
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
